role_ctrl_regs: RTL and testbench
=================================

Name: role_ctrl_regs

Overview:
- AXI4-Lite slave register file sitting directly downstream of the role's s_axi_ctrl port.
- Terminates host control accesses (20-bit address, 32-bit data).
- Drives the role's core-reset hold, I/O enable and 36-bit memory window base.
- Exposes a free-running cycle counter and a status readback for host software.

Parameters:
- ID_VALUE, 32'h524F_4C45, constant returned by the ID register
- ADDR_W, 20, s_axi_ctrl address width
- MEM_ADDR_W, 36, width of mem_base output

Ports:
- aclk  in  1  clock
- areset  in  1  synchronous active-high reset
- s_axi_ctrl_awaddr  in  20  write address
- s_axi_ctrl_awvalid  in  1  write address valid
- s_axi_ctrl_awready  out  1  write address ready
- s_axi_ctrl_wdata  in  32  write data
- s_axi_ctrl_wstrb  in  4  byte strobes
- s_axi_ctrl_wvalid  in  1  write data valid
- s_axi_ctrl_wready  out  1  write data ready
- s_axi_ctrl_bresp  out  2  write response
- s_axi_ctrl_bvalid  out  1  write response valid
- s_axi_ctrl_bready  in  1  write response ready
- s_axi_ctrl_araddr  in  20  read address
- s_axi_ctrl_arvalid  in  1  read address valid
- s_axi_ctrl_arready  out  1  read address ready
- s_axi_ctrl_rdata  out  32  read data
- s_axi_ctrl_rresp  out  2  read response
- s_axi_ctrl_rvalid  out  1  read data valid
- s_axi_ctrl_rready  in  1  read data ready
- core_reset  out  1  holds the role core in reset while 1
- io_enable  out  1  gates the role's m_axi_io master
- mem_base  out  36  offset added to role m_axi_mem addresses
- core_busy  in  1  status input from the role core

Behaviour:
- One clock (aclk); reset is synchronous and active-high (areset). All outputs are registered.
- Reset values:
  - awready=1, wready=1, arready=1, bvalid=0, rvalid=0, bresp=0, rresp=0, rdata=0.
  - core_reset=1, io_enable=0, mem_base=0, scratch=0, cycle counter=0, snapshot=0.
- Decode uses awaddr/araddr[7:2]. Bits [19:8] are ignored, so the map aliases every 256 B.
- Register map:
  - 0x00 ID: RO, returns ID_VALUE.
  - 0x04 CTRL: RW. bit0 core_reset, bit1 io_enable; other bits read 0.
  - 0x08 MEM_BASE_LO: RW, mem_base[31:0].
  - 0x0C MEM_BASE_HI: RW, bits[3:0] = mem_base[35:32]; other bits read 0.
  - 0x10 SCRATCH: RW, 32 bits.
  - 0x14 CYCLE_LO: RO. Returns counter[31:0] and, in the same cycle, latches counter[63:32] into the snapshot.
  - 0x18 CYCLE_HI: RO, returns the snapshot.
  - 0x1C STATUS: RO. bit0 core_busy, bit1 core_reset, bit2 io_enable.
  - Any other offset: reads return 0 with rresp=2'b10 (SLVERR); writes are dropped with bresp=2'b10.
  - Writes to RO offsets are dropped with bresp=2'b00 (OKAY).
- Write strobes apply per byte. A byte with wstrb=0 keeps its old value.
- Write path:
  - AW and W are captured independently, in either order or in the same cycle.
  - awready deasserts the cycle after AW capture; wready deasserts the cycle after W capture.
  - Once both are held, the register is updated and bvalid=1 in the same cycle, i.e. 1 cycle after the later handshake.
  - bvalid holds with a stable bresp until bready. On the bvalid&bready cycle, awready and wready return to 1 in the next cycle.
  - Only one write is outstanding at a time.
- Read path:
  - arready=1 when rvalid=0 and drops the cycle after the AR handshake.
  - rdata, rresp and rvalid are presented 1 cycle after the AR handshake and hold stable until rready.
  - arready returns to 1 the cycle after rvalid&rready.
- Simultaneous read and write:
  - Read and write channels are fully independent.
  - A read whose AR handshake coincides with the write-commit cycle of the same register returns the pre-write value.
- Cycle counter: 64 bits, increments every cycle outside reset, wraps from 2^64-1 to 0.
- areset asserted mid-transaction aborts it: pending AW/W/B/R are discarded and all state returns to reset values.

Decomposition:
- Shared package role_ctrl_pkg holds:
  - register offset constants: REG_ID, REG_CTRL, REG_MEM_BASE_LO, REG_MEM_BASE_HI, REG_SCRATCH, REG_CYCLE_LO, REG_CYCLE_HI, REG_STATUS;
  - RESP_OKAY=2'b00, RESP_SLVERR=2'b10;
  - CTRL bit indices.
- One natural sub-module: axil_slave_if. It handles the AW/W/B/AR/R handshakes and emits single-cycle wr_en/addr/data/strb and rd_en/addr strobes. The top level keeps the register storage and decode.

Test Plan:
- Reset, then read 0x00 and 0x04 -> 32'h524F_4C45 and 32'h1, both rresp=0, rvalid exactly 1 cycle after AR handshake.
- Write 0x04 = 32'h2 with W two cycles before AW -> bvalid 1 cycle after AW, bresp=0, core_reset=0, io_enable=1 from that cycle onward.
- Write 0x10 = 32'hDEADBEEF with wstrb=4'b0101, starting from SCRATCH=0 -> readback 32'h00AD00EF.
- Write 0x08 = 32'h8000_0000 and 0x0C = 32'hFFFF_FFF3 -> mem_base=36'h3_8000_0000; 0x0C reads 32'h3.
- Read 0x40 and write 0x40 -> rdata=0, rresp=2'b10; bresp=2'b10; no register changes. Hold rready=0 for 5 cycles -> rvalid and rdata stay stable.
- Read CYCLE_LO, idle 100 cycles, read CYCLE_HI -> HI equals counter[63:32] at the CYCLE_LO read. Assert areset during an outstanding bvalid -> next cycle bvalid=0 and core_reset=1.

Source files
------------

// File: rtl/role_ctrl_pkg.sv
// Shared register map, response codes and byte-strobe helper for the role control register file.
package role_ctrl_pkg;

  localparam logic [7:0] REG_ID          = 8'h00;
  localparam logic [7:0] REG_CTRL        = 8'h04;
  localparam logic [7:0] REG_MEM_BASE_LO = 8'h08;
  localparam logic [7:0] REG_MEM_BASE_HI = 8'h0C;
  localparam logic [7:0] REG_SCRATCH     = 8'h10;
  localparam logic [7:0] REG_CYCLE_LO    = 8'h14;
  localparam logic [7:0] REG_CYCLE_HI    = 8'h18;
  localparam logic [7:0] REG_STATUS      = 8'h1C;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int CTRL_CORE_RESET_BIT = 0;
  localparam int CTRL_IO_ENABLE_BIT  = 1;

  function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/role_ctrl_regs_if.sv
// AXI4-Lite control bus between the host-side master and the role register file.
interface role_ctrl_regs_if #(
  parameter int ADDR_W = 20
);
  logic [ADDR_W-1:0] awaddr;
  logic              awvalid;
  logic              awready;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axil_slave_if.sv
// AXI4-Lite handshake engine: captures AW/W independently, one write and one read outstanding,
// and hands single-cycle write/read strobes to the register decode.
module axil_slave_if
  import role_ctrl_pkg::*;
#(
  parameter int ADDR_W = 20
) (
  input  logic              clk,
  input  logic              rst,
  role_ctrl_regs_if.slave   bus,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic [3:0]        wr_strb,
  input  logic [1:0]        wr_resp,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [31:0]       rd_data,
  input  logic [1:0]        rd_resp
);

  logic              awready_q, awready_d;
  logic              wready_q, wready_d;
  logic              aw_held_q, aw_held_d;
  logic              w_held_q, w_held_d;
  logic [ADDR_W-1:0] awaddr_q, awaddr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic              bvalid_q, bvalid_d;
  logic [1:0]        bresp_q, bresp_d;
  logic              arready_q, arready_d;
  logic              rvalid_q, rvalid_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [1:0]        rresp_q, rresp_d;
  logic              aw_hs, w_hs;

  always_comb begin
    awready_d = awready_q;
    wready_d  = wready_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;

    aw_hs = bus.awvalid & awready_q;
    w_hs  = bus.wvalid & wready_q;

    if (aw_hs) begin
      aw_held_d = 1'b1;
      awaddr_d  = bus.awaddr;
      awready_d = 1'b0;
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      wdata_d  = bus.wdata;
      wstrb_d  = bus.wstrb;
      wready_d = 1'b0;
    end

    // Commit on the edge of the later handshake so the register and bvalid change together.
    wr_addr = aw_held_q ? awaddr_q : bus.awaddr;
    wr_data = w_held_q ? wdata_q : bus.wdata;
    wr_strb = w_held_q ? wstrb_q : bus.wstrb;
    wr_en   = (aw_hs | aw_held_q) & (w_hs | w_held_q) & ~bvalid_q;

    if (wr_en) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = wr_resp;
    end
    if (bvalid_q & bus.bready) begin
      bvalid_d  = 1'b0;
      awready_d = 1'b1;
      wready_d  = 1'b1;
    end

    rd_en   = bus.arvalid & arready_q;
    rd_addr = bus.araddr;
    if (rd_en) begin
      arready_d = 1'b0;
      rvalid_d  = 1'b1;
      rdata_d   = rd_data;
      rresp_d   = rd_resp;
    end
    if (rvalid_q & bus.rready) begin
      rvalid_d  = 1'b0;
      arready_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      awready_q <= 1'b1;
      wready_q  <= 1'b1;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      awready_q <= awready_d;
      wready_q  <= wready_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  // Captured address/data are only consumed while the matching held flag is set.
  always_ff @(posedge clk) begin
    awaddr_q <= awaddr_d;
    wdata_q  <= wdata_d;
    wstrb_q  <= wstrb_d;
  end

  assign bus.awready = awready_q;
  assign bus.wready  = wready_q;
  assign bus.bvalid  = bvalid_q;
  assign bus.bresp   = bresp_q;
  assign bus.arready = arready_q;
  assign bus.rvalid  = rvalid_q;
  assign bus.rdata   = rdata_q;
  assign bus.rresp   = rresp_q;

endmodule

// File: rtl/role_ctrl_regs.sv
// Role control register file: core reset hold, I/O enable, memory window base,
// scratch, 64-bit cycle counter with snapshot, and status readback.
module role_ctrl_regs
  import role_ctrl_pkg::*;
#(
  parameter logic [31:0] ID_VALUE   = 32'h524F_4C45,
  parameter int          ADDR_W     = 20,
  parameter int          MEM_ADDR_W = 36
) (
  input  logic                  aclk,
  input  logic                  areset,
  role_ctrl_regs_if.slave       s_axi_ctrl,
  output logic                  core_reset,
  output logic                  io_enable,
  output logic [MEM_ADDR_W-1:0] mem_base,
  input  logic                  core_busy
);

  logic              wr_en, rd_en;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic [31:0]       wr_data, rd_data;
  logic [3:0]        wr_strb;
  logic [1:0]        wr_resp, rd_resp;

  axil_slave_if #(.ADDR_W(ADDR_W)) u_axil (
    .clk     (aclk),
    .rst     (areset),
    .bus     (s_axi_ctrl),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .wr_strb (wr_strb),
    .wr_resp (wr_resp),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .rd_resp (rd_resp)
  );

  logic                  core_reset_q, core_reset_d;
  logic                  io_enable_q, io_enable_d;
  logic [MEM_ADDR_W-1:0] mem_base_q, mem_base_d;
  logic [31:0]           scratch_q, scratch_d;
  logic [63:0]           cnt_q, cnt_d;
  logic [31:0]           snap_q, snap_d;

  logic [7:0]  wr_off, rd_off;
  logic        wr_hit, rd_hit;
  logic [31:0] hi_merge, ctrl_rd, status_rd;
  logic        unused_addr_bits;

  // Only [7:2] decode; upper bits alias the 32-byte map every 256 bytes.
  assign wr_off = {wr_addr[7:2], 2'b00};
  assign rd_off = {rd_addr[7:2], 2'b00};
  assign wr_hit = (wr_addr[7:5] == 3'b000);
  assign rd_hit = (rd_addr[7:5] == 3'b000);
  assign wr_resp = wr_hit ? RESP_OKAY : RESP_SLVERR;
  assign rd_resp = rd_hit ? RESP_OKAY : RESP_SLVERR;

  assign unused_addr_bits = ^{wr_addr[ADDR_W-1:8], wr_addr[1:0],
                              rd_addr[ADDR_W-1:8], rd_addr[1:0],
                              hi_merge[31:MEM_ADDR_W-32]};

  always_comb begin
    core_reset_d = core_reset_q;
    io_enable_d  = io_enable_q;
    mem_base_d   = mem_base_q;
    scratch_d    = scratch_q;
    cnt_d        = cnt_q + 64'd1;
    snap_d       = snap_q;
    hi_merge     = apply_strb(32'(mem_base_q[MEM_ADDR_W-1:32]), wr_data, wr_strb);

    if (wr_en && wr_hit) begin
      case (wr_off)
        REG_CTRL: begin
          if (wr_strb[0]) begin
            core_reset_d = wr_data[CTRL_CORE_RESET_BIT];
            io_enable_d  = wr_data[CTRL_IO_ENABLE_BIT];
          end
        end
        REG_MEM_BASE_LO: mem_base_d[31:0] = apply_strb(mem_base_q[31:0], wr_data, wr_strb);
        REG_MEM_BASE_HI: mem_base_d[MEM_ADDR_W-1:32] = hi_merge[MEM_ADDR_W-33:0];
        REG_SCRATCH:     scratch_d = apply_strb(scratch_q, wr_data, wr_strb);
        default: ;
      endcase
    end

    // Reading the low counter word freezes the high word for a coherent 64-bit read.
    if (rd_en && rd_hit && (rd_off == REG_CYCLE_LO)) snap_d = cnt_q[63:32];
  end

  always_comb begin
    ctrl_rd = '0;
    ctrl_rd[CTRL_CORE_RESET_BIT] = core_reset_q;
    ctrl_rd[CTRL_IO_ENABLE_BIT]  = io_enable_q;
    status_rd = 32'({io_enable_q, core_reset_q, core_busy});
    rd_data = '0;
    if (rd_hit) begin
      case (rd_off)
        REG_ID:          rd_data = ID_VALUE;
        REG_CTRL:        rd_data = ctrl_rd;
        REG_MEM_BASE_LO: rd_data = mem_base_q[31:0];
        REG_MEM_BASE_HI: rd_data = 32'(mem_base_q[MEM_ADDR_W-1:32]);
        REG_SCRATCH:     rd_data = scratch_q;
        REG_CYCLE_LO:    rd_data = cnt_q[31:0];
        REG_CYCLE_HI:    rd_data = snap_q;
        REG_STATUS:      rd_data = status_rd;
        default:         rd_data = '0;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      core_reset_q <= 1'b1;
      io_enable_q  <= 1'b0;
      mem_base_q   <= '0;
      scratch_q    <= '0;
      cnt_q        <= '0;
      snap_q       <= '0;
    end else begin
      core_reset_q <= core_reset_d;
      io_enable_q  <= io_enable_d;
      mem_base_q   <= mem_base_d;
      scratch_q    <= scratch_d;
      cnt_q        <= cnt_d;
      snap_q       <= snap_d;
    end
  end

  assign core_reset = core_reset_q;
  assign io_enable  = io_enable_q;
  assign mem_base   = mem_base_q;

endmodule

// File: tb/tb_role_ctrl_regs.sv
// Directed bench for role_ctrl_regs with a register-map model and a per-cycle output compare.
module tb_role_ctrl_regs;

  logic        aclk;
  logic        areset;
  logic        core_busy;
  logic        core_reset;
  logic        io_enable;
  logic [35:0] mem_base;

  role_ctrl_regs_if #(.ADDR_W(20)) bus ();

  role_ctrl_regs #(
    .ID_VALUE   (32'h524F_4C45),
    .ADDR_W     (20),
    .MEM_ADDR_W (36)
  ) dut (
    .aclk       (aclk),
    .areset     (areset),
    .s_axi_ctrl (bus),
    .core_reset (core_reset),
    .io_enable  (io_enable),
    .mem_base   (mem_base),
    .core_busy  (core_busy)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Model state of the register map.
  logic        m_cr, m_io;
  logic [35:0] m_mem_base;
  logic [31:0] m_scratch, m_snap;
  logic [63:0] m_cnt;

  always @(posedge aclk) m_cnt <= areset ? 64'd0 : m_cnt + 64'd1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_cr = 1'b1; m_io = 1'b0; m_mem_base = '0; m_scratch = '0; m_snap = '0;
  endtask

  function automatic logic [31:0] bmerge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = n[8*i +: 8];
    return r;
  endfunction

  function automatic logic [1:0] model_resp(input logic [19:0] a);
    return (a[7:0] < 8'h20) ? 2'b00 : 2'b10;
  endfunction

  task automatic model_write(input logic [19:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] t;
    case (a[7:0] & 8'hFC)
      8'h04: begin t = bmerge({30'd0, m_io, m_cr}, d, s); m_cr = t[0]; m_io = t[1]; end
      8'h08: m_mem_base[31:0] = bmerge(m_mem_base[31:0], d, s);
      8'h0C: begin t = bmerge({28'd0, m_mem_base[35:32]}, d, s); m_mem_base[35:32] = t[3:0]; end
      8'h10: m_scratch = bmerge(m_scratch, d, s);
      default: ;
    endcase
  endtask

  function automatic logic [33:0] model_read(input logic [19:0] a, input logic [63:0] cnt);
    logic [31:0] d;
    d = 32'd0;
    case (a[7:0] & 8'hFC)
      8'h00: d = 32'h524F_4C45;
      8'h04: d = {30'd0, m_io, m_cr};
      8'h08: d = m_mem_base[31:0];
      8'h0C: d = {28'd0, m_mem_base[35:32]};
      8'h10: d = m_scratch;
      8'h14: d = cnt[31:0];
      8'h18: d = m_snap;
      8'h1C: d = {29'd0, m_io, m_cr, core_busy};
      default: d = 32'd0;
    endcase
    return {model_resp(a), d};
  endfunction

  always @(negedge aclk) begin
    if (cmp_en && !areset) begin
      chk("core_reset", core_reset, m_cr);
      chk("io_enable", io_enable, m_io);
      chk("mem_base", mem_base, m_mem_base);
    end
  end

  task automatic axi_read(input logic [19:0] a, input int hold, output logic [31:0] d, output logic [1:0] r);
    logic [33:0] e;
    logic [63:0] cnt;
    logic [31:0] d0;
    int n;
    bus.araddr = a; bus.arvalid = 1'b1; n = 0;
    while (!bus.arready && n < 20) begin @(posedge aclk); #1; n++; end
    chk("ar_wait", bus.arready, 1'b1);
    cnt = m_cnt;
    e = model_read(a, cnt);
    @(posedge aclk); #1;
    bus.arvalid = 1'b0;
    if ((a[7:0] & 8'hFC) == 8'h14) m_snap = cnt[63:32];
    chk("rvalid_latency", bus.rvalid, 1'b1);
    chk("arready_drop", bus.arready, 1'b0);
    d0 = bus.rdata;
    for (int i = 0; i < hold; i++) begin
      @(posedge aclk); #1;
      chk("rvalid_hold", bus.rvalid, 1'b1);
      chk("rdata_hold", bus.rdata, d0);
    end
    d = bus.rdata; r = bus.rresp;
    chk("rdata", d, e[31:0]);
    chk("rresp", r, e[33:32]);
    bus.rready = 1'b1;
    @(posedge aclk); #1;
    bus.rready = 1'b0;
    chk("rvalid_clear", bus.rvalid, 1'b0);
    chk("arready_back", bus.arready, 1'b1);
  endtask

  // lead > 0: W that many cycles before AW; lead < 0: AW first; 0: same cycle.
  task automatic axi_write(input logic [19:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int lead, input bit no_b);
    logic [1:0] er;
    er = model_resp(a);
    if (lead > 0) begin
      bus.wdata = d; bus.wstrb = s; bus.wvalid = 1'b1;
      @(posedge aclk); #1; bus.wvalid = 1'b0;
      chk("wready_drop", bus.wready, 1'b0);
      for (int i = 1; i < lead; i++) begin @(posedge aclk); #1; end
      chk("bvalid_early", bus.bvalid, 1'b0);
      bus.awaddr = a; bus.awvalid = 1'b1;
    end else if (lead < 0) begin
      bus.awaddr = a; bus.awvalid = 1'b1;
      @(posedge aclk); #1; bus.awvalid = 1'b0;
      chk("awready_drop", bus.awready, 1'b0);
      for (int i = 1; i < -lead; i++) begin @(posedge aclk); #1; end
      chk("bvalid_early", bus.bvalid, 1'b0);
      bus.wdata = d; bus.wstrb = s; bus.wvalid = 1'b1;
    end else begin
      bus.awaddr = a; bus.awvalid = 1'b1;
      bus.wdata = d; bus.wstrb = s; bus.wvalid = 1'b1;
    end
    @(posedge aclk); #1;
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    chk("bvalid_latency", bus.bvalid, 1'b1);
    chk("bresp", bus.bresp, er);
    chk("awready_busy", bus.awready, 1'b0);
    if (er == 2'b00) model_write(a, d, s);
    if (!no_b) begin
      @(posedge aclk); #1;
      chk("bvalid_hold", bus.bvalid, 1'b1);
      chk("bresp_hold", bus.bresp, er);
      bus.bready = 1'b1;
      @(posedge aclk); #1;
      bus.bready = 1'b0;
      chk("bvalid_clear", bus.bvalid, 1'b0);
      chk("aw_w_ready_back", {bus.awready, bus.wready}, 2'b11);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    logic [31:0] lo;

    areset = 1'b1; core_busy = 1'b0;
    bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
    bus.bready = 1'b0; bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
    model_reset();
    repeat (3) @(posedge aclk);
    #1;
    chk("rst_ready", {bus.awready, bus.wready, bus.arready}, 3'b111);
    chk("rst_valid", {bus.bvalid, bus.rvalid}, 2'b00);
    chk("rst_resp", {bus.bresp, bus.rresp}, 4'b0000);
    chk("rst_rdata", bus.rdata, 32'd0);
    chk("rst_outputs", {core_reset, io_enable, mem_base}, {1'b1, 1'b0, 36'd0});
    areset = 1'b0;
    cmp_en = 1'b1;

    axi_read(20'h00000, 0, d, r);
    chk("id_literal", {r, d}, {2'b00, 32'h524F_4C45});
    axi_read(20'h00004, 0, d, r);
    chk("ctrl_reset_literal", {r, d}, {2'b00, 32'h1});

    axi_write(20'h00004, 32'h2, 4'hF, 2, 1'b0);
    chk("ctrl_outputs_literal", {core_reset, io_enable}, 2'b01);

    axi_write(20'h00010, 32'hDEADBEEF, 4'b0101, 0, 1'b0);
    axi_read(20'h00010, 0, d, r);
    chk("scratch_strb_literal", d, 32'h00AD00EF);

    axi_write(20'h00008, 32'h8000_0000, 4'hF, -1, 1'b0);
    axi_write(20'h0000C, 32'hFFFF_FFF3, 4'hF, 0, 1'b0);
    chk("mem_base_literal", mem_base, 36'h3_8000_0000);
    axi_read(20'h0000C, 0, d, r);
    chk("mem_hi_literal", d, 32'h3);

    axi_read(20'h00040, 5, d, r);
    chk("bad_read_literal", {r, d}, {2'b10, 32'd0});
    axi_write(20'h00040, 32'hFFFF_FFFF, 4'hF, 0, 1'b0);
    axi_read(20'h00010, 0, d, r);
    chk("scratch_after_bad", d, 32'h00AD00EF);

    axi_write(20'h00110, 32'h1234_5678, 4'hF, -2, 1'b0);
    axi_read(20'hABC10, 0, d, r);
    chk("alias_literal", d, 32'h1234_5678);

    core_busy = 1'b1;
    axi_read(20'h0001C, 0, d, r);
    chk("status_literal", d, 32'h5);
    core_busy = 1'b0;

    axi_write(20'h00000, 32'h0, 4'hF, 0, 1'b0);
    axi_read(20'h00000, 0, d, r);
    chk("id_after_ro_write", d, 32'h524F_4C45);

    fork
      axi_write(20'h00010, 32'hAAAA_5555, 4'hF, 0, 1'b0);
      begin
        logic [31:0] dd;
        logic [1:0]  rr;
        axi_read(20'h00010, 0, dd, rr);
        chk("pre_write_literal", dd, 32'h1234_5678);
      end
    join
    axi_read(20'h00010, 0, d, r);
    chk("post_write_literal", d, 32'hAAAA_5555);

    axi_read(20'h00014, 0, lo, r);
    repeat (100) @(posedge aclk);
    #1;
    axi_read(20'h00018, 0, d, r);
    chk("cycle_hi_literal", d, 32'd0);

    axi_write(20'h00004, 32'h3, 4'hF, 0, 1'b1);
    areset = 1'b1;
    model_reset();
    @(posedge aclk); #1;
    chk("abort_bvalid", bus.bvalid, 1'b0);
    chk("abort_core_reset", core_reset, 1'b1);
    chk("abort_ready", {bus.awready, bus.wready, bus.arready}, 3'b111);
    areset = 1'b0;
    axi_read(20'h00004, 0, d, r);
    chk("ctrl_after_abort", d, 32'h1);
    axi_read(20'h00010, 0, d, r);
    chk("scratch_after_abort", d, 32'h0);

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
